// File: rtl/vio_route_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vio_route_ctrl_if                                               |
// | Purpose  : Bundles the route-update request handshake and the per-region   |
// |            user-to-switch stream monitor taps of vio_route_ctrl.           |
// | Signals  : cfg_valid / cfg_ready   - route update request handshake        |
// |            cfg_region              - target region index                   |
// |            cfg_route               - new route (switch tdest) word         |
// |            mon_tvalid/tready/tlast - per-region stream monitor taps        |
// | Modports : master - requester and stream side                              |
// |            slave  - route controller side                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface vio_route_ctrl_if #(
  parameter int N_ID       = 12,
  parameter int ROUTE_BITS = 14
) ();

  localparam int RW = (N_ID > 1) ? $clog2(N_ID) : 1;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [RW-1:0]         cfg_region;
  logic [ROUTE_BITS-1:0] cfg_route;

  logic [N_ID-1:0]       mon_tvalid;
  logic [N_ID-1:0]       mon_tready;
  logic [N_ID-1:0]       mon_tlast;

  modport master (
    output cfg_valid,
    output cfg_region,
    output cfg_route,
    output mon_tvalid,
    output mon_tready,
    output mon_tlast,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_region,
    input  cfg_route,
    input  mon_tvalid,
    input  mon_tready,
    input  mon_tlast,
    output cfg_ready
  );

endinterface
`default_nettype wire

// File: rtl/vio_route_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vio_route_ctrl                                                  |
// | Purpose  : Safe runtime update of the per-region switch route table.       |
// |            An update waits for the target region to reach a packet        |
// |            boundary, gates that region, lets the path settle for          |
// |            SETTLE_CYCLES quiet cycles, then commits the new route.        |
// | Ports    : aclk, areset  - clock, synchronous active-high reset            |
// |            cfg (slave)   - update handshake + stream monitor taps          |
// |            route_in      - route table driven to the switch                |
// |            hold          - per-region sink gate (integrator ANDs ~hold)    |
// |            busy          - update in progress                              |
// |            err           - sticky out-of-range region request              |
// |            upd_cnt       - committed update count, wraps modulo 2^32       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vio_route_ctrl #(
  parameter int                    N_ID          = 12,
  parameter int                    ROUTE_BITS    = 14,
  parameter int                    SETTLE_CYCLES = 4,
  parameter logic [ROUTE_BITS-1:0] RST_ROUTE     = '0
) (
  input  logic                                aclk,
  input  logic                                areset,
  vio_route_ctrl_if.slave                     cfg,
  output logic [N_ID-1:0][ROUTE_BITS-1:0]     route_in,
  output logic [N_ID-1:0]                     hold,
  output logic                                busy,
  output logic                                err,
  output logic [31:0]                         upd_cnt
);

  localparam int RW   = (N_ID > 1) ? $clog2(N_ID) : 1;
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST =
    SC_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic SETTLE_BYPASS = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_SETTLE = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                            state_q,     state_d;
  logic [RW-1:0]                     region_q,    region_d;
  logic [ROUTE_BITS-1:0]             route_q,     route_d;
  logic [SC_W-1:0]                   cnt_q,       cnt_d;
  logic [N_ID-1:0]                   in_pkt_q,    in_pkt_d;
  logic [N_ID-1:0][ROUTE_BITS-1:0]   route_tbl_q, route_tbl_d;
  logic                              err_q,       err_d;
  logic [31:0]                       upd_cnt_q,   upd_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [N_ID-1:0] w_mon_hs;
  logic            w_region_ok;
  logic            w_sel_hs;
  logic            w_sel_in_pkt;

  assign w_mon_hs     = cfg.mon_tvalid & cfg.mon_tready;
  assign w_region_ok  = (int'(cfg.cfg_region) < N_ID);
  // region_q only ever holds an in-range index, so these selects are safe.
  assign w_sel_hs     = w_mon_hs[region_q];
  assign w_sel_in_pkt = in_pkt_q[region_q];

  // Packet tracking: a non-last beat opens a packet, a last beat closes it.
  // A single-beat packet therefore never raises the flag.
  assign in_pkt_d = (in_pkt_q & ~w_mon_hs) | (w_mon_hs & ~cfg.mon_tlast);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    route_d     = route_q;
    cnt_d       = cnt_q;
    route_tbl_d = route_tbl_q;
    err_d       = err_q;
    upd_cnt_d   = upd_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg.cfg_valid) begin
          if (w_region_ok) begin
            region_d = cfg.cfg_region;
            route_d  = cfg.cfg_route;
            state_d  = S_DRAIN;
          end else begin
            // Rejected request is consumed; the table is left untouched.
            err_d = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        // Leave only on a quiet cycle at a packet boundary.
        if (!w_sel_in_pkt && !w_sel_hs) begin
          cnt_d   = '0;
          state_d = SETTLE_BYPASS ? S_COMMIT : S_SETTLE;
        end
      end

      S_SETTLE: begin
        // Any activity on the region restarts the quiet window. in_pkt is
        // included so that a packet opened here is never cut by the commit.
        if (w_sel_hs || w_sel_in_pkt) begin
          cnt_d = '0;
        end else if (cnt_q == SC_LAST) begin
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q + SC_W'(1);
        end
      end

      S_COMMIT: begin
        route_tbl_d[region_q] = route_q;
        upd_cnt_d             = upd_cnt_q + 32'd1;
        state_d               = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      region_q    <= '0;
      route_q     <= '0;
      cnt_q       <= '0;
      in_pkt_q    <= '0;
      route_tbl_q <= {N_ID{RST_ROUTE}};
      err_q       <= 1'b0;
      upd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      route_q     <= route_d;
      cnt_q       <= cnt_d;
      in_pkt_q    <= in_pkt_d;
      route_tbl_q <= route_tbl_d;
      err_q       <= err_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cfg.cfg_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;
  assign upd_cnt       = upd_cnt_q;
  assign route_in      = route_tbl_q;

  // Gate only the target region, and only once its in-flight packet is done.
  for (genvar i = 0; i < N_ID; i++) begin : g_hold
    assign hold[i] = (state_q != S_IDLE) && (region_q == RW'(i)) && !in_pkt_q[i];
  end

endmodule
`default_nettype wire
